univ_shift_reg: RTL and testbench

//  Parametrised W-bit register with async active-low reset, sync clear, enable and four

---
 rtl/usr_pkg.sv | 7 +
 rtl/dff_en_arst.sv | 18 +
 rtl/univ_shift_reg.sv | 101 ++++++++++
 tb/tb_univ_shift_reg.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: operating mode encodings.
package usr_pkg;
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;
endpackage

// File: rtl/dff_en_arst.sv
// Single-bit flip-flop with clock enable and asynchronous active-low reset to RST_BIT.
module dff_en_arst #(
    parameter bit RST_BIT = 1'b0
) (
    input  logic Clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            q <= RST_BIT;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load with optional
// rotate, plus a saturating shift counter that pulses done on the WIDTH-th shift after a load.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               ROTATE    = 1'b0,
    parameter int               CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             ser_in_msb,
    input  logic             ser_in_lsb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_lsb,
    output logic             ser_out_msb,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             done
);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX_M1 = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shr_val;
    logic [WIDTH-1:0] shl_val;
    logic [WIDTH-1:0] q_nxt;
    logic             bit_en;
    logic             is_shift;

    // A one-bit register has no neighbour, so the shifted-in bit replaces it outright.
    generate
        if (WIDTH == 1) begin : g_w1
            assign shr_val = ROTATE ? q : ser_in_msb;
            assign shl_val = ROTATE ? q : ser_in_lsb;
        end else begin : g_wn
            assign shr_val = {(ROTATE ? q[0] : ser_in_msb), q[WIDTH-1:1]};
            assign shl_val = {q[WIDTH-2:0], (ROTATE ? q[WIDTH-1] : ser_in_lsb)};
        end
    endgenerate

    always_comb begin
        q_nxt = q;
        if (clr) begin
            q_nxt = RESET_VAL;
        end else begin
            case (mode)
                MODE_SHR:  q_nxt = shr_val;
                MODE_SHL:  q_nxt = shl_val;
                MODE_LOAD: q_nxt = d;
                default:   q_nxt = q;
            endcase
        end
    end

    assign bit_en   = clr | (en & (mode != MODE_HOLD));
    assign is_shift = (mode == MODE_SHR) || (mode == MODE_SHL);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            dff_en_arst #(
                .RST_BIT(RESET_VAL[i])
            ) u_bit (
                .Clk(Clk),
                .rst(rst),
                .en (bit_en),
                .d  (q_nxt[i]),
                .q  (q[i])
            );
        end
    endgenerate

    assign ser_out_lsb = q[0];
    assign ser_out_msb = q[WIDTH-1];

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            shift_cnt <= '0;
            done      <= 1'b0;
        end else if (clr) begin
            shift_cnt <= '0;
            done      <= 1'b0;
        end else if (!en) begin
            done <= 1'b0;
        end else if (mode == MODE_LOAD) begin
            shift_cnt <= '0;
            done      <= 1'b0;
        end else if (is_shift) begin
            // Counter saturates so shifting beyond WIDTH never re-triggers done.
            if (shift_cnt != CNT_MAX) begin
                shift_cnt <= shift_cnt + 1'b1;
            end
            done <= (shift_cnt == CNT_MAX_M1);
        end else begin
            done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: three instances (8-bit plain, 8-bit rotate, 1-bit) against a model.
module tb_univ_shift_reg;
    logic Clk = 1'b0;
    logic rst = 1'b0;
    always #5 Clk = ~Clk;

    logic       clr_s   [3];
    logic       en_s    [3];
    logic [1:0] mode_s  [3];
    logic       smsb_s  [3];
    logic       slsb_s  [3];
    logic [7:0] d_s     [3];

    logic [7:0] q_a, q_b;
    logic [0:0] q_c;
    logic [3:0] cnt_a, cnt_b;
    logic [0:0] cnt_c;
    logic       done_a, done_b, done_c;
    logic       lsb_a, lsb_b, lsb_c, msb_a, msb_b, msb_c;

    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00), .ROTATE(1'b0)) u_a (
        .Clk(Clk), .rst(rst), .clr(clr_s[0]), .en(en_s[0]), .mode(mode_s[0]),
        .ser_in_msb(smsb_s[0]), .ser_in_lsb(slsb_s[0]), .d(d_s[0]), .q(q_a),
        .ser_out_lsb(lsb_a), .ser_out_msb(msb_a), .shift_cnt(cnt_a), .done(done_a));
    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00), .ROTATE(1'b1)) u_b (
        .Clk(Clk), .rst(rst), .clr(clr_s[1]), .en(en_s[1]), .mode(mode_s[1]),
        .ser_in_msb(smsb_s[1]), .ser_in_lsb(slsb_s[1]), .d(d_s[1]), .q(q_b),
        .ser_out_lsb(lsb_b), .ser_out_msb(msb_b), .shift_cnt(cnt_b), .done(done_b));
    univ_shift_reg #(.WIDTH(1), .RESET_VAL(1'b0), .ROTATE(1'b0)) u_c (
        .Clk(Clk), .rst(rst), .clr(clr_s[2]), .en(en_s[2]), .mode(mode_s[2]),
        .ser_in_msb(smsb_s[2]), .ser_in_lsb(slsb_s[2]), .d(d_s[2][0:0]), .q(q_c),
        .ser_out_lsb(lsb_c), .ser_out_msb(msb_c), .shift_cnt(cnt_c), .done(done_c));

    logic [7:0] obs_q    [3];
    logic [3:0] obs_cnt  [3];
    logic       obs_done [3];
    logic       obs_lsb  [3];
    logic       obs_msb  [3];
    assign obs_q[0] = q_a;          assign obs_q[1] = q_b;          assign obs_q[2] = {7'b0, q_c};
    assign obs_cnt[0] = cnt_a;      assign obs_cnt[1] = cnt_b;      assign obs_cnt[2] = {3'b0, cnt_c};
    assign obs_done[0] = done_a;    assign obs_done[1] = done_b;    assign obs_done[2] = done_c;
    assign obs_lsb[0] = lsb_a;      assign obs_lsb[1] = lsb_b;      assign obs_lsb[2] = lsb_c;
    assign obs_msb[0] = msb_a;      assign obs_msb[1] = msb_b;      assign obs_msb[2] = msb_c;

    // Reference model: register value as an integer, shifts as arithmetic on it.
    int         wid [3] = '{8, 8, 1};
    bit         rot [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] m_q    [3];
    int         m_cnt  [3];
    bit         m_done [3];

    int passed = 0;
    int total  = 0;

    function automatic logic [7:0] model_shift(logic [7:0] v, int w, bit r, bit right, bit sin);
        int mask, in_bit, res;
        mask = (1 << w) - 1;
        if (right) begin
            in_bit = r ? int'(v & 8'h01) : int'(sin);
            res = ((int'(v) >> 1) | (in_bit << (w - 1))) & mask;
        end else begin
            in_bit = r ? ((int'(v) >> (w - 1)) & 1) : int'(sin);
            res = ((int'(v) << 1) | in_bit) & mask;
        end
        return 8'(res);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_q[k] = 8'h00; m_cnt[k] = 0; m_done[k] = 1'b0;
        end
    endtask

    task automatic model_step(int k);
        if (clr_s[k]) begin
            m_q[k] = 8'h00; m_cnt[k] = 0; m_done[k] = 1'b0;
        end else if (!en_s[k] || mode_s[k] == 2'b00) begin
            m_done[k] = 1'b0;
        end else if (mode_s[k] == 2'b11) begin
            m_q[k] = 8'((int'(d_s[k])) & ((1 << wid[k]) - 1));
            m_cnt[k] = 0; m_done[k] = 1'b0;
        end else begin
            m_q[k] = model_shift(m_q[k], wid[k], rot[k], mode_s[k] == 2'b01,
                                 mode_s[k] == 2'b01 ? smsb_s[k] : slsb_s[k]);
            m_done[k] = (m_cnt[k] == wid[k] - 1);
            m_cnt[k] = (m_cnt[k] + 1 > wid[k]) ? wid[k] : m_cnt[k] + 1;
        end
    endtask

    // Drive one clock edge on instance k, advance its model, then idle it again.
    task automatic cycle(int k, bit c, bit e, logic [1:0] m, bit smsb, bit slsb, logic [7:0] dv);
        clr_s[k] = c; en_s[k] = e; mode_s[k] = m; smsb_s[k] = smsb; slsb_s[k] = slsb; d_s[k] = dv;
        @(posedge Clk);
        model_step(k);
        #1;
        clr_s[k] = 1'b0; en_s[k] = 1'b0;
    endtask

    task automatic test_reset();
        clr_s[0] = 1'b0; en_s[0] = 1'b1; mode_s[0] = 2'b11; d_s[0] = 8'hFF;
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        total++; if (q_a !== 8'h00) $display("FAIL reset_q: got %h want 00", q_a); else passed++;
        total++; if (cnt_a !== 4'd0) $display("FAIL reset_cnt: got %0d want 0", cnt_a); else passed++;
        total++; if (done_a !== 1'b0) $display("FAIL reset_done: got %b want 0", done_a); else passed++;
        total++; if (q_b !== 8'h00 || q_c !== 1'b0) $display("FAIL reset_qbc: got %h %b want 00 0", q_b, q_c); else passed++;
        en_s[0] = 1'b0;
        @(negedge Clk);
        rst = 1'b1;
    endtask

    task automatic test_shift_right();
        logic [7:0] seq;
        seq = 8'b1010_0101;
        cycle(0, 0, 1, 2'b11, 0, 0, 8'hA5);
        total++; if (q_a !== 8'hA5) $display("FAIL load_a5: got %h want a5", q_a); else passed++;
        for (int i = 0; i < 8; i++) begin
            total++; if (lsb_a !== seq[i]) $display("FAIL ser_out_lsb[%0d]: got %b want %b", i, lsb_a, seq[i]); else passed++;
            cycle(0, 0, 1, 2'b01, 0, 0, 8'h00);
            total++; if (cnt_a !== 4'(i + 1)) $display("FAIL shr_cnt[%0d]: got %0d want %0d", i, cnt_a, i + 1); else passed++;
            total++; if (done_a !== (i == 7)) $display("FAIL shr_done[%0d]: got %b want %b", i, done_a, i == 7); else passed++;
            total++; if (q_a !== m_q[0]) $display("FAIL shr_q[%0d]: got %h want %h", i, q_a, m_q[0]); else passed++;
        end
        total++; if (q_a !== 8'h00) $display("FAIL shr_final: got %h want 00", q_a); else passed++;
        cycle(0, 0, 1, 2'b01, 1, 0, 8'h00);
        total++; if (cnt_a !== 4'd8 || done_a !== 1'b0) $display("FAIL shr_sat: got cnt %0d done %b want 8 0", cnt_a, done_a); else passed++;
        total++; if (q_a !== 8'h80) $display("FAIL shr_in_msb: got %h want 80", q_a); else passed++;
    endtask

    task automatic test_rotate();
        cycle(1, 0, 1, 2'b11, 0, 0, 8'h81);
        cycle(1, 0, 1, 2'b10, 0, 0, 8'h00);
        total++; if (q_b !== 8'h03) $display("FAIL rot_shl1: got %h want 03", q_b); else passed++;
        for (int i = 1; i < 8; i++) cycle(1, 0, 1, 2'b10, 0, 0, 8'h00);
        total++; if (q_b !== 8'h81) $display("FAIL rot_shl8: got %h want 81", q_b); else passed++;
        total++; if (done_b !== 1'b1 || cnt_b !== 4'd8) $display("FAIL rot_done: got done %b cnt %0d want 1 8", done_b, cnt_b); else passed++;
        cycle(1, 0, 1, 2'b01, 0, 0, 8'h00);
        total++; if (q_b !== 8'hC0 || done_b !== 1'b0) $display("FAIL rot_shr: got %h done %b want c0 0", q_b, done_b); else passed++;
    endtask

    task automatic test_enable_clr();
        cycle(0, 0, 1, 2'b11, 0, 0, 8'h0F);
        repeat (3) cycle(0, 0, 1, 2'b01, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 2'b01, 1, 1, 8'hFF);
            total++; if (q_a !== 8'h01 || cnt_a !== 4'd3) $display("FAIL en_hold[%0d]: got %h cnt %0d want 01 3", i, q_a, cnt_a); else passed++;
        end
        cycle(0, 1, 0, 2'b11, 0, 0, 8'hFF);
        total++; if (q_a !== 8'h00 || cnt_a !== 4'd0 || done_a !== 1'b0) $display("FAIL clr: got %h cnt %0d done %b want 00 0 0", q_a, cnt_a, done_a); else passed++;
    endtask

    task automatic test_async_reset();
        cycle(0, 0, 1, 2'b11, 0, 0, 8'($urandom_range(1, 255)));
        repeat (5) cycle(0, 0, 1, 2'($urandom_range(1, 2)), 1'($urandom), 1'($urandom), 8'h00);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        total++; if (q_a !== 8'h00 || cnt_a !== 4'd0 || done_a !== 1'b0) $display("FAIL arst_now: got %h cnt %0d done %b want 00 0 0", q_a, cnt_a, done_a); else passed++;
        @(negedge Clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 2'b10, 1, 1, 8'h00);
            total++; if (cnt_a !== 4'(i + 1) || done_a !== 1'b0) $display("FAIL arst_after[%0d]: got cnt %0d done %b want %0d 0", i, cnt_a, done_a, i + 1); else passed++;
        end
        total++; if (q_a !== 8'h07) $display("FAIL arst_q: got %h want 07", q_a); else passed++;
    endtask

    task automatic test_width1();
        cycle(2, 0, 1, 2'b11, 0, 0, 8'h01);
        total++; if (q_c !== 1'b1) $display("FAIL w1_load: got %b want 1", q_c); else passed++;
        cycle(2, 0, 1, 2'b10, 1, 0, 8'h00);
        total++; if (q_c !== 1'b0 || cnt_c !== 1'b1 || done_c !== 1'b1) $display("FAIL w1_shl: got q %b cnt %b done %b want 0 1 1", q_c, cnt_c, done_c); else passed++;
        cycle(2, 0, 1, 2'b01, 1, 0, 8'h00);
        total++; if (q_c !== 1'b1 || cnt_c !== 1'b1 || done_c !== 1'b0) $display("FAIL w1_shr: got q %b cnt %b done %b want 1 1 0", q_c, cnt_c, done_c); else passed++;
    endtask

    task automatic test_random();
        int k, r;
        bit c, e;
        logic [1:0] m;
        for (int n = 0; n < 600; n++) begin
            k = $urandom_range(0, 2);
            r = $urandom_range(0, 99);
            c = (r < 3);
            e = ($urandom_range(0, 9) != 0);
            r = $urandom_range(0, 99);
            m = (r < 8) ? 2'b11 : (r < 15) ? 2'b00 : (r < 57) ? 2'b01 : 2'b10;
            total++; if (obs_lsb[k] !== m_q[k][0] || obs_msb[k] !== m_q[k][wid[k]-1])
                $display("FAIL rnd_ser[%0d] dut%0d: got %b%b want %b%b", n, k, obs_msb[k], obs_lsb[k], m_q[k][wid[k]-1], m_q[k][0]);
            else passed++;
            cycle(k, c, e, m, 1'($urandom), 1'($urandom), 8'($urandom));
            total++; if (obs_q[k] !== m_q[k] || obs_cnt[k] !== 4'(m_cnt[k]) || obs_done[k] !== m_done[k])
                $display("FAIL rnd[%0d] dut%0d: got q %h cnt %0d done %b want %h %0d %b", n, k, obs_q[k], obs_cnt[k], obs_done[k], m_q[k], m_cnt[k], m_done[k]);
            else passed++;
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            clr_s[k] = 1'b0; en_s[k] = 1'b0; mode_s[k] = 2'b00;
            smsb_s[k] = 1'b0; slsb_s[k] = 1'b0; d_s[k] = 8'h00;
        end
        test_reset();
        test_shift_right();
        test_rotate();
        test_enable_clr();
        test_async_reset();
        test_width1();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
